// File: rtl/dual_port_ram.sv
// True dual-port synchronous RAM with per-port valid/ready handshake.
// Same-address conflicts involving a write are arbitrated round-robin.
module dual_port_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic                  we_a,
  input  logic                  valid_a,
  output logic                  ready_a,
  output logic [DATA_WIDTH-1:0] q_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic                  we_b,
  input  logic                  valid_b,
  output logic                  ready_b,
  output logic [DATA_WIDTH-1:0] q_b
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  active;
  logic                  prio_b;
  logic                  conflict;
  logic                  acc_a;
  logic                  acc_b;

  // Two reads of one word never collide; only write-involved same-address pairs do.
  always_comb begin
    conflict = valid_a && valid_b && (addr_a == addr_b) && (we_a || we_b);
    ready_a  = active && (!conflict || !prio_b);
    ready_b  = active && (!conflict || prio_b);
    acc_a    = valid_a && ready_a;
    acc_b    = valid_b && ready_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      q_a    <= '0;
      q_b    <= '0;
      prio_b <= 1'b0;
      active <= 1'b0;
    end else begin
      active <= 1'b1;
      if (conflict && active) prio_b <= !prio_b;
      if (acc_a) begin
        if (we_a) mem[addr_a] <= data_a;
        else      q_a         <= mem[addr_a];
      end
      if (acc_b) begin
        if (we_b) mem[addr_b] <= data_b;
        else      q_b         <= mem[addr_b];
      end
    end
  end

endmodule

// File: tb/tb_dual_port_ram.sv
// Randomized self-checking bench for dual_port_ram against a behavioural model.
module tb_dual_port_ram;

  logic       clk;
  logic       rst_n;
  logic [3:0] addr_a, addr_b;
  logic [7:0] data_a, data_b;
  logic       we_a, we_b, valid_a, valid_b;
  logic       ready_a, ready_b;
  logic [7:0] q_a, q_b;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model state
  logic [7:0] m_mem [16];
  logic [7:0] m_q_a, m_q_b;
  logic       m_turn_b;
  logic       m_active;

  dual_port_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .addr_a(addr_a), .data_a(data_a), .we_a(we_a), .valid_a(valid_a),
    .ready_a(ready_a), .q_a(q_a),
    .addr_b(addr_b), .data_b(data_b), .we_b(we_b), .valid_b(valid_b),
    .ready_b(ready_b), .q_b(q_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_q_a    = 8'h00;
    m_q_b    = 8'h00;
    m_turn_b = 1'b0;
    m_active = 1'b0;
  endtask

  task automatic idle();
    valid_a = 1'b0; valid_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
    addr_a = 4'h0; addr_b = 4'h0; data_a = 8'h00; data_b = 8'h00;
  endtask

  // One cycle: apply at negedge, check grants, clock, check read data.
  task automatic drive(input logic va, input logic wa, input logic [3:0] aa, input logic [7:0] da,
                       input logic vb, input logic wb, input logic [3:0] ab, input logic [7:0] db);
    logic clash, grant_a, grant_b;
    logic [7:0] rd_a, rd_b;
    valid_a = va; we_a = wa; addr_a = aa; data_a = da;
    valid_b = vb; we_b = wb; addr_b = ab; data_b = db;
    #1;
    clash = va && vb && (aa == ab) && (wa || wb);
    if (!m_active) begin
      grant_a = 1'b0; grant_b = 1'b0;
    end else if (clash) begin
      grant_a = !m_turn_b; grant_b = m_turn_b;
    end else begin
      grant_a = 1'b1; grant_b = 1'b1;
    end
    check("ready_a", 8'(ready_a), 8'(grant_a));
    check("ready_b", 8'(ready_b), 8'(grant_b));
    @(posedge clk);
    rd_a = m_mem[aa];
    rd_b = m_mem[ab];
    if (va && grant_a) begin
      if (wa) m_mem[aa] = da; else m_q_a = rd_a;
    end
    if (vb && grant_b) begin
      if (wb) m_mem[ab] = db; else m_q_b = rd_b;
    end
    if (clash && m_active) m_turn_b = !m_turn_b;
    m_active = 1'b1;
    #1;
    check("q_a", q_a, m_q_a);
    check("q_b", q_b, m_q_b);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_q_a", q_a, 8'h00);
    check("rst_q_b", q_b, 8'h00);
    check("rst_ready_a", 8'(ready_a), 8'h00);
    check("rst_ready_b", 8'(ready_b), 8'h00);
    rst_n = 1'b1;

    // first edge after release: not yet active, nothing accepted
    drive(1'b1, 1'b0, 4'd5, 8'h00, 1'b1, 1'b0, 4'd9, 8'h00);
    drive(1'b1, 1'b0, 4'd5, 8'h00, 1'b1, 1'b0, 4'd9, 8'h00);
    check("rst_read_a", q_a, 8'h00);

    // basic write then read on both ports
    drive(1'b1, 1'b1, 4'd3, 8'h5A, 1'b0, 1'b0, 4'd0, 8'h00);
    drive(1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    check("basic_q_a", q_a, 8'h5A);
    drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd3, 8'h00);
    check("basic_q_b", q_b, 8'h5A);

    // independent parallel writes then crossed reads
    drive(1'b1, 1'b1, 4'd1, 8'h11, 1'b1, 1'b1, 4'd2, 8'h22);
    drive(1'b1, 1'b0, 4'd2, 8'h00, 1'b1, 1'b0, 4'd1, 8'h00);
    check("par_q_a", q_a, 8'h22);
    check("par_q_b", q_b, 8'h11);

    // write/write conflict: A wins first, B follows
    drive(1'b1, 1'b1, 4'd7, 8'hAA, 1'b1, 1'b1, 4'd7, 8'hBB);
    drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 4'd7, 8'hBB);
    drive(1'b1, 1'b0, 4'd7, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    check("ww_q_a", q_a, 8'hBB);
    // second conflict: B holds priority now
    valid_a = 1'b1; we_a = 1'b1; addr_a = 4'd8; valid_b = 1'b1; we_b = 1'b1; addr_b = 4'd8;
    #1;
    check("ww2_ready_a", 8'(ready_a), 8'h00);
    check("ww2_ready_b", 8'(ready_b), 8'h01);
    drive(1'b1, 1'b1, 4'd8, 8'hC1, 1'b1, 1'b1, 4'd8, 8'hC2);
    drive(1'b1, 1'b1, 4'd8, 8'hC1, 1'b0, 1'b0, 4'd0, 8'h00);

    // read/write conflict with priority back at A
    drive(1'b1, 1'b0, 4'd4, 8'h00, 1'b1, 1'b1, 4'd4, 8'h33);
    check("rw_q_a", q_a, 8'h00);
    drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 4'd4, 8'h33);
    drive(1'b1, 1'b0, 4'd4, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
    check("rw_q_a2", q_a, 8'h33);

    // same-address dual read
    drive(1'b1, 1'b0, 4'd3, 8'h00, 1'b1, 1'b0, 4'd3, 8'h00);
    check("rr_q_a", q_a, 8'h5A);
    check("rr_q_b", q_b, 8'h5A);

    // asynchronous reset pulse mid-cycle
    idle();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_q_a", q_a, 8'h00);
    check("arst_q_b", q_b, 8'h00);
    check("arst_ready_a", 8'(ready_a), 8'h00);
    #1 rst_n = 1'b1;
    @(posedge clk);
    m_active = 1'b1;
    @(negedge clk);
    drive(1'b1, 1'b0, 4'd3, 8'h00, 1'b1, 1'b0, 4'd7, 8'h00);
    check("arst_rd3", q_a, 8'h00);

    // randomized traffic on a narrow address window to provoke conflicts
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 8'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 8'($urandom));
    end
    for (int n = 0; n < 100; n++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom),
            1'b1, 1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
